// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between the IF fetch port and the MEM load/store port.
// Build option: define MEM_PORT_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data priority + starvation guard).
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic             d_ready_q, d_ready_d;
  logic             busy_q, busy_d;
  logic             grant_s;
  logic             pick_data_s;

  assign grant_s = if_req | d_req;

`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On contention the port not granted last wins; uncontested requests win outright.
  always_comb begin
    if (if_req && d_req) begin
      pick_data_s = (last_owner_q == OWN_IF);
    end else begin
      pick_data_s = d_req;
    end
    if ((state_q == S_IDLE) && grant_s) begin
      last_owner_d = pick_data_s ? OWN_D : OWN_IF;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Last-owner register; reset to D so the first contested grant goes to fetch.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_owner_q <= OWN_D;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  // Data wins unless fetch has waited through STARVE_MAX consecutive data grants.
  always_comb begin
    pick_data_s = d_req && !(if_req && (starve_q == STARVE_LIM));
    if (state_q != S_IDLE) begin
      starve_d = starve_q;
    end else if (if_req && pick_data_s) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : (starve_q + 4'd1);
    end else begin
      starve_d = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (clr) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Access sequencer: grant in IDLE, count down the memory latency, pulse ready in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d     = S_ACCESS;
          cnt_d       = LAT_INIT;
          mem_en_d    = 1'b1;
          owner_d     = pick_data_s ? OWN_D : OWN_IF;
          mem_we_d    = pick_data_s ? d_we : 1'b0;
          mem_addr_d  = pick_data_s ? d_addr : if_addr;
          mem_wdata_d = pick_data_s ? d_wdata : {WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          // Stores complete without touching the owner's read-data register.
          if (!mem_we_q && (owner_q == OWN_D)) begin
            d_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            if_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          if (owner_q == OWN_D) begin
            d_ready_d = 1'b1;
          end else begin
            if_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; clr drops any in-flight access without a ready pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {WIDTH{1'b0}};
      mem_wdata_q <= {WIDTH{1'b0}};
      if_rdata_q  <= {WIDTH{1'b0}};
      d_rdata_q   <= {WIDTH{1'b0}};
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory (instruction + data) between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage RISC pipeline.
- Sequences each access through a small FSM: grant, memory enable, fixed-latency wait, one-cycle ready pulse back to the winning requester.
- The pipeline holds PC/IFID (fetch) or EXMEM (data) stalled until its ready pulse.

Parameters:
- WIDTH, 32, data and address width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  WIDTH  fetch address; stable while if_req.
- if_rdata  out  WIDTH  fetched instruction; valid when if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; level, held until d_ready.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  store data.
- d_rdata  out  WIDTH  load data; valid when d_ready.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, registered.
- mem_we  out  1  memory write enable, registered; only meaningful with mem_en.
- mem_addr  out  WIDTH  memory address, registered.
- mem_wdata  out  WIDTH  memory write data, registered.
- mem_rdata  in  WIDTH  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (clr=1 at posedge):
  - state=IDLE; all outputs 0, including if_rdata/d_rdata.
  - Latency counter = 0; starvation counter = 0.
  - Any in-flight access is dropped with no ready pulse. The requester re-presents after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled here.
  - On a grant, the edge latches mem_addr/mem_wdata/mem_we from the winner, sets mem_en=1, records owner (IF or D), loads cnt=MEM_LAT, and moves to ACCESS.
  - With no request, stays in IDLE with mem_en=0.
- ACCESS:
  - mem_en=1 only in the first ACCESS cycle (the cycle after the grant edge); 0 afterwards.
  - cnt decrements each cycle. The cycle where cnt==1 is the cycle MEM_LAT after the mem_en cycle; mem_rdata is valid in that cycle.
  - At that edge, the arbiter registers mem_rdata into the owner's rdata (loads only; stores leave rdata unchanged) and moves to RESP.
- RESP:
  - The owner's ready=1 for exactly this one cycle; the other ready stays 0.
  - Requests are ignored in RESP.
  - Next state is IDLE unconditionally.
  - A requester must drop req in the cycle after ready; a req still high in IDLE is a new access.
- Latency: req seen in IDLE at edge E gives ready high in cycle E+MEM_LAT+1, counting cycles after E. Throughput is one access per MEM_LAT+2 cycles.
- Arbitration in IDLE (default):
  - Data has priority over fetch, since MEM-stage stall backs up the whole pipe.
  - Starvation counter increments on each data grant while if_req=1, saturating at STARVE_MAX.
  - It clears on any fetch grant, and in any IDLE cycle with if_req=0.
  - If if_req=1 and counter==STARVE_MAX, fetch wins even when d_req=1.
- Simultaneous events:
  - Both requests with counter<STARVE_MAX: data is granted.
  - A request arriving during ACCESS/RESP waits; no queue beyond the held level request.
- rdata registers hold their value until the next completion for the same port or reset.
- Address/data are not checked or aligned; the arbiter passes them through unchanged.

Optional Feature:
- Macro: MEM_PORT_ARB_ROUND_ROBIN_EN.
- When defined:
  - Fixed priority and the starvation counter are removed.
  - A 1-bit last_owner register (reset = D, so the first contested grant goes to IF) selects the winner on contention: the port not granted last wins.
  - Uncontested requests are granted immediately.
- When undefined: data priority with STARVE_MAX starvation guard as above.
- Ports and timing are identical in both builds.

Test Plan:
- Single load, MEM_LAT=2:
  - Stimulus: d_req=1, d_we=0, d_addr=0x40; memory returns 0xDEADBEEF.
  - Response: mem_en one cycle with mem_addr=0x40, mem_we=0; d_ready pulses 3 cycles after the grant edge with d_rdata=0xDEADBEEF; if_ready stays 0.
- Single store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x10, d_wdata=0x12345678.
  - Response: one mem_en cycle with mem_we=1, mem_wdata=0x12345678; d_ready pulse; d_rdata keeps its previous value.
- Contention, default build:
  - Stimulus: if_req and d_req held high together; d_req re-asserted immediately after each d_ready; STARVE_MAX=4.
  - Response: grants go D,D,D,D,IF; if_rdata equals the memory word at if_addr.
- Back-to-back fetches:
  - Stimulus: if_req re-raised in the cycle after each if_ready, if_addr = 0, 1, 2.
  - Response: three if_ready pulses spaced MEM_LAT+2=4 cycles apart; busy low exactly one cycle between accesses.
- Reset mid-access:
  - Stimulus: clr=1 in the second ACCESS cycle of a load.
  - Response: next cycle all outputs 0, busy=0, no d_ready; after clr falls with d_req still high, a fresh access completes normally.
- Round-robin build (MEM_PORT_ARB_ROUND_ROBIN_EN defined):
  - Stimulus: both requests held continuously.
  - Response: grants alternate IF, D, IF, D, with IF first after reset.
